pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
- Pipeline sequencer for the 5-stage RV32I core. It decides, per cycle, whether the PC, IF/ID and ID/EX registers advance, hold or are flushed.
- Inputs are decode-stage operand usage, the EX-stage instruction's destination/load status, the EX-stage jump request, and the start/done handshake of the multi-cycle execute unit.
- Small FSM arbitrates three stall sources: taken jump, multi-cycle wait and load-use hazard. It also drives the PC redirect.

Parameters:
- FLUSH_CYCLES, 1, cycles IF/ID and ID/EX are flushed per taken jump (legal range 1..4).
- MC_TIMEOUT, 64, maximum cycles spent in MC_WAIT before forced release (legal range >= 2).

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- id_rs1_addr_i  in  5  rs1 index of the instruction in ID.
- id_rs2_addr_i  in  5  rs2 index of the instruction in ID.
- id_rs1_ren_i  in  1  ID instruction reads rs1.
- id_rs2_ren_i  in  1  ID instruction reads rs2.
- ex_rd_addr_i  in  5  rd of the instruction in EX.
- ex_reg_wen_i  in  1  EX instruction writes rd.
- ex_mem_ren_i  in  1  EX instruction is a load.
- ex_jump_en_i  in  1  EX resolves a taken branch/jump.
- ex_jump_addr_i  in  32  jump target.
- mc_start_i  in  1  1-cycle pulse: multi-cycle op begins in EX.
- mc_done_i  in  1  1-cycle pulse: multi-cycle result valid.
- hold_pc_o  out  1  PC keeps its value.
- hold_if_id_o  out  1  IF/ID keeps its value.
- hold_id_ex_o  out  1  ID/EX keeps its value.
- flush_if_id_o  out  1  IF/ID loads a NOP.
- flush_id_ex_o  out  1  ID/EX loads a NOP (bubble).
- jump_en_o  out  1  PC loads jump_addr_o.
- jump_addr_o  out  32  PC redirect target.
- mc_timeout_o  out  1  1-cycle pulse on forced MC release.

Behaviour:
- Reset: while rst_n=0 at a rising edge, state<=IDLE and flush/timeout counters<=0. While rst_n=0, all control outputs are driven 0 combinationally and jump_addr_o=0. Reset mid-MC_WAIT or mid-FLUSH abandons the operation with no timeout pulse.
- State encoding: IDLE, LU_STALL, MC_WAIT, FLUSH.
- Outputs are combinational from state and inputs. There is no registered latency on control outputs.
- Load-use hazard (lu) = ex_mem_ren_i & ex_reg_wen_i & (ex_rd_addr_i!=0) & ((id_rs1_ren_i & id_rs1_addr_i==ex_rd_addr_i) | (id_rs2_ren_i & id_rs2_addr_i==ex_rd_addr_i)).
- Priority in IDLE: jump > mc_start > lu.
- IDLE, ex_jump_en_i=1:
  - jump_en_o=1, jump_addr_o=ex_jump_addr_i, flush_if_id_o=1, flush_id_ex_o=1.
  - If FLUSH_CYCLES>1, go to FLUSH with counter=FLUSH_CYCLES-1; otherwise stay in IDLE.
  - mc_start_i and lu are ignored in that cycle.
- IDLE, mc_start_i=1 (no jump): assert hold_pc_o, hold_if_id_o and hold_id_ex_o in the same cycle. Go to MC_WAIT with timeout counter=0.
- IDLE, lu=1 (no jump, no mc_start): assert hold_pc_o, hold_if_id_o and flush_id_ex_o. Go to LU_STALL.
- LU_STALL: 1 cycle, no hold/flush asserted, lu ignored. Always return to IDLE. A new lu in the following IDLE cycle is evaluated normally.
- MC_WAIT: hold_pc_o, hold_if_id_o and hold_id_ex_o all asserted.
  - On mc_done_i=1: in that cycle the holds drop and the pipeline advances; go to IDLE.
  - Otherwise the counter increments. When the counter reaches MC_TIMEOUT-1 without done: mc_timeout_o=1, holds drop, go to IDLE.
  - ex_jump_en_i and mc_start_i are ignored in MC_WAIT.
- FLUSH: flush_if_id_o=1 and flush_id_ex_o=1 each cycle; the counter decrements and the FSM returns to IDLE when it reaches 1.
  - A new ex_jump_en_i in FLUSH is ignored, because EX holds a bubble.
- mc_done_i outside MC_WAIT is ignored.
- hold and flush on the same register are never both asserted.
- The timeout counter is $clog2(MC_TIMEOUT) bits wide; the flush counter is 3 bits.

Optional Feature:
- Macro PIPE_CTRL_PERF_EN.
- Defined: adds outputs stall_cnt_o[31:0] and flush_cnt_o[31:0], both saturating at 32'hFFFF_FFFF and cleared by reset.
  - stall_cnt_o increments on every cycle in which hold_pc_o=1.
  - flush_cnt_o increments once per taken jump.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Constants in common/defines.v: state encodings (`CTRL_IDLE`, `CTRL_LU_STALL`, `CTRL_MC_WAIT`, `CTRL_FLUSH`), the NOP encoding 32'h0000_0013 used by the flushed stages, and `ZERO_REG`.
- One sub-module, hazard_detect: purely combinational lu compare (inputs: id rs addresses/ren, ex rd/wen/mem_ren; output: lu). Instantiated once in pipe_ctrl.

Test Plan:
- Load-use stall: lw x5 in EX (ex_mem_ren_i=1, rd=5), ID add reads rs2=5. Cycle 0: hold_pc_o=1, hold_if_id_o=1, flush_id_ex_o=1. Cycle 1: state LU_STALL, all controls 0. Cycle 2: IDLE.
- No false stall on x0: the same load with rd=0, or rd=5 with id_rs2_ren_i=0, produces no hold/flush in any cycle.
- Jump with FLUSH_CYCLES=2: ex_jump_en_i=1, addr=32'h0000_0100 leads to:
  - Cycle 0: jump_en_o=1, jump_addr_o=32'h100, both flushes.
  - Cycle 1: both flushes, jump_en_o=0.
  - Cycle 2: IDLE.
- Jump over lu: ex_jump_en_i and lu together leads to jump/flush only, no hold, and no LU_STALL entry.
- Multi-cycle op: mc_start_i at cycle 0 and mc_done_i at cycle 10 means holds are high in cycles 0-9, low in cycle 10, and mc_timeout_o is never asserted.
- Timeout: MC_TIMEOUT=8 with mc_start_i and no done means mc_timeout_o=1 for exactly one cycle 8 cycles after start, holds drop, and the FSM returns to IDLE.
- Reset mid-operation: rst_n=0 during MC_WAIT clears holds, and after release the FSM is in IDLE with no timeout pulse.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : pipe_ctrl_pkg
// Brief  : Shared FSM encoding and architectural constants for pipe_ctrl.
// Rev    : 1.0  initial release
// ============================================================================
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    CTRL_IDLE     = 2'd0,
    CTRL_LU_STALL = 2'd1,
    CTRL_MC_WAIT  = 2'd2,
    CTRL_FLUSH    = 2'd3
  } ctrl_state_e;

  // Encoding loaded into a flushed stage (addi x0, x0, 0).
  localparam logic [31:0] c_NOP_INSN = 32'h0000_0013;
  localparam logic [4:0]  c_ZERO_REG = 5'd0;

endpackage
`default_nettype wire

// File: rtl/pipe_ctrl_hazard_detect.sv
`default_nettype none
// ============================================================================
// Module : pipe_ctrl_hazard_detect
// Brief  : Combinational load-use compare between the ID operands and EX rd.
// Rev    : 1.0  initial release
// ============================================================================
module pipe_ctrl_hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] id_rs1_addr_i,
  input  logic [4:0] id_rs2_addr_i,
  input  logic       id_rs1_ren_i,
  input  logic       id_rs2_ren_i,
  input  logic [4:0] ex_rd_addr_i,
  input  logic       ex_reg_wen_i,
  input  logic       ex_mem_ren_i,
  output logic       lu_o
);

  logic w_rs1_hit;
  logic w_rs2_hit;
  logic w_ex_load_wr;

  // x0 is hardwired, so a load targeting it never creates a dependency.
  assign w_ex_load_wr = ex_mem_ren_i & ex_reg_wen_i & (ex_rd_addr_i != c_ZERO_REG);
  assign w_rs1_hit    = id_rs1_ren_i & (id_rs1_addr_i == ex_rd_addr_i);
  assign w_rs2_hit    = id_rs2_ren_i & (id_rs2_addr_i == ex_rd_addr_i);
  assign lu_o         = w_ex_load_wr & (w_rs1_hit | w_rs2_hit);

endmodule
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module : pipe_ctrl
// Brief  : Pipeline sequencer arbitrating jump flush, multi-cycle wait and
//          load-use stall. Optional perf counters under PIPE_CTRL_PERF_EN.
// Rev    : 1.0  initial release
// ============================================================================
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int MC_TIMEOUT   = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  id_rs1_addr_i,
  input  logic [4:0]  id_rs2_addr_i,
  input  logic        id_rs1_ren_i,
  input  logic        id_rs2_ren_i,
  input  logic [4:0]  ex_rd_addr_i,
  input  logic        ex_reg_wen_i,
  input  logic        ex_mem_ren_i,
  input  logic        ex_jump_en_i,
  input  logic [31:0] ex_jump_addr_i,
  input  logic        mc_start_i,
  input  logic        mc_done_i,
  output logic        hold_pc_o,
  output logic        hold_if_id_o,
  output logic        hold_id_ex_o,
  output logic        flush_if_id_o,
  output logic        flush_id_ex_o,
  output logic        jump_en_o,
  output logic [31:0] jump_addr_o,
`ifdef PIPE_CTRL_PERF_EN
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o,
`endif
  output logic        mc_timeout_o
);

  localparam int                c_TO_W      = $clog2(MC_TIMEOUT);
  localparam logic [c_TO_W-1:0] c_TO_LAST   = c_TO_W'(MC_TIMEOUT - 1);
  localparam logic [2:0]        c_FLUSH_INI = 3'(FLUSH_CYCLES - 1);

  ctrl_state_e       r_state;
  ctrl_state_e       w_state_nxt;
  logic [2:0]        r_flush_cnt;
  logic [2:0]        w_flush_nxt;
  logic [c_TO_W-1:0] r_to_cnt;
  logic [c_TO_W-1:0] w_to_nxt;
  logic              w_lu;

  pipe_ctrl_hazard_detect u_hazard_detect (
    .id_rs1_addr_i (id_rs1_addr_i),
    .id_rs2_addr_i (id_rs2_addr_i),
    .id_rs1_ren_i  (id_rs1_ren_i),
    .id_rs2_ren_i  (id_rs2_ren_i),
    .ex_rd_addr_i  (ex_rd_addr_i),
    .ex_reg_wen_i  (ex_reg_wen_i),
    .ex_mem_ren_i  (ex_mem_ren_i),
    .lu_o          (w_lu)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= CTRL_IDLE;
      r_flush_cnt <= '0;
      r_to_cnt    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_flush_cnt <= w_flush_nxt;
      r_to_cnt    <= w_to_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_flush_nxt   = r_flush_cnt;
    w_to_nxt      = r_to_cnt;
    hold_pc_o     = 1'b0;
    hold_if_id_o  = 1'b0;
    hold_id_ex_o  = 1'b0;
    flush_if_id_o = 1'b0;
    flush_id_ex_o = 1'b0;
    jump_en_o     = 1'b0;
    jump_addr_o   = '0;
    mc_timeout_o  = 1'b0;
    if (rst_n) begin
      case (r_state)
        CTRL_IDLE: begin
          if (ex_jump_en_i) begin
            jump_en_o     = 1'b1;
            jump_addr_o   = ex_jump_addr_i;
            flush_if_id_o = 1'b1;
            flush_id_ex_o = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              w_state_nxt = CTRL_FLUSH;
              w_flush_nxt = c_FLUSH_INI;
            end
          end else if (mc_start_i) begin
            hold_pc_o    = 1'b1;
            hold_if_id_o = 1'b1;
            hold_id_ex_o = 1'b1;
            w_state_nxt  = CTRL_MC_WAIT;
            w_to_nxt     = '0;
          end else if (w_lu) begin
            hold_pc_o     = 1'b1;
            hold_if_id_o  = 1'b1;
            flush_id_ex_o = 1'b1;
            w_state_nxt   = CTRL_LU_STALL;
          end
        end
        CTRL_LU_STALL: w_state_nxt = CTRL_IDLE;
        CTRL_MC_WAIT: begin
          // Done and timeout both release the holds in the same cycle.
          if (mc_done_i) begin
            w_state_nxt = CTRL_IDLE;
          end else if (r_to_cnt == c_TO_LAST) begin
            mc_timeout_o = 1'b1;
            w_state_nxt  = CTRL_IDLE;
          end else begin
            hold_pc_o    = 1'b1;
            hold_if_id_o = 1'b1;
            hold_id_ex_o = 1'b1;
            w_to_nxt     = r_to_cnt + 1'b1;
          end
        end
        CTRL_FLUSH: begin
          flush_if_id_o = 1'b1;
          flush_id_ex_o = 1'b1;
          if (r_flush_cnt <= 3'd1) begin
            w_state_nxt = CTRL_IDLE;
          end else begin
            w_flush_nxt = r_flush_cnt - 3'd1;
          end
        end
        default: w_state_nxt = CTRL_IDLE;
      endcase
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_jflush_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall_cnt  <= '0;
      r_jflush_cnt <= '0;
    end else begin
      if (hold_pc_o && (r_stall_cnt != 32'hFFFF_FFFF)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      if (jump_en_o && (r_jflush_cnt != 32'hFFFF_FFFF)) begin
        r_jflush_cnt <= r_jflush_cnt + 32'd1;
      end
    end
  end

  assign stall_cnt_o = r_stall_cnt;
  assign flush_cnt_o = r_jflush_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_pipe_ctrl
// Brief  : Directed self-checking bench; instance A (FLUSH_CYCLES=2,
//          MC_TIMEOUT=16) and instance B (FLUSH_CYCLES=1, MC_TIMEOUT=8).
// Rev    : 1.0  initial release
// ============================================================================
module tb_pipe_ctrl;

  // Control vector: {hold_pc, hold_if_id, hold_id_ex, flush_if_id, flush_id_ex, jump_en, mc_timeout}
  localparam logic [6:0] c_ZERO = 7'b000_0000;
  localparam logic [6:0] c_H3   = 7'b111_0000;
  localparam logic [6:0] c_LU   = 7'b110_0100;
  localparam logic [6:0] c_JF   = 7'b000_1110;
  localparam logic [6:0] c_FL   = 7'b000_1100;
  localparam logic [6:0] c_TO   = 7'b000_0001;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rs1, rs2, rd;
  logic        ren1, ren2, wen, mren, jen, mstart, mdone;
  logic [31:0] jaddr;

  logic        hpc_a, hif_a, hex_a, fif_a, fex_a, jen_a, to_a;
  logic        hpc_b, hif_b, hex_b, fif_b, fex_b, jen_b, to_b;
  logic [31:0] jadr_a, jadr_b;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] scnt_a, fcnt_a, scnt_b, fcnt_b;
`endif

  logic [6:0] ctl_a, ctl_b;
  assign ctl_a = {hpc_a, hif_a, hex_a, fif_a, fex_a, jen_a, to_a};
  assign ctl_b = {hpc_b, hif_b, hex_b, fif_b, fex_b, jen_b, to_b};

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.FLUSH_CYCLES(2), .MC_TIMEOUT(16)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .id_rs1_addr_i(rs1), .id_rs2_addr_i(rs2), .id_rs1_ren_i(ren1), .id_rs2_ren_i(ren2),
    .ex_rd_addr_i(rd), .ex_reg_wen_i(wen), .ex_mem_ren_i(mren),
    .ex_jump_en_i(jen), .ex_jump_addr_i(jaddr), .mc_start_i(mstart), .mc_done_i(mdone),
    .hold_pc_o(hpc_a), .hold_if_id_o(hif_a), .hold_id_ex_o(hex_a),
    .flush_if_id_o(fif_a), .flush_id_ex_o(fex_a), .jump_en_o(jen_a), .jump_addr_o(jadr_a),
`ifdef PIPE_CTRL_PERF_EN
    .stall_cnt_o(scnt_a), .flush_cnt_o(fcnt_a),
`endif
    .mc_timeout_o(to_a)
  );

  pipe_ctrl #(.FLUSH_CYCLES(1), .MC_TIMEOUT(8)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .id_rs1_addr_i(rs1), .id_rs2_addr_i(rs2), .id_rs1_ren_i(ren1), .id_rs2_ren_i(ren2),
    .ex_rd_addr_i(rd), .ex_reg_wen_i(wen), .ex_mem_ren_i(mren),
    .ex_jump_en_i(jen), .ex_jump_addr_i(jaddr), .mc_start_i(mstart), .mc_done_i(mdone),
    .hold_pc_o(hpc_b), .hold_if_id_o(hif_b), .hold_id_ex_o(hex_b),
    .flush_if_id_o(fif_b), .flush_id_ex_o(fex_b), .jump_en_o(jen_b), .jump_addr_o(jadr_b),
`ifdef PIPE_CTRL_PERF_EN
    .stall_cnt_o(scnt_b), .flush_cnt_o(fcnt_b),
`endif
    .mc_timeout_o(to_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Settle combinational outputs, compare both instances, then advance one clock.
  task automatic cyc(input string tag, input logic [6:0] ea, input logic [6:0] eb);
    #1;
    chk({tag, "/A"}, {25'd0, ctl_a}, {25'd0, ea});
    chk({tag, "/B"}, {25'd0, ctl_b}, {25'd0, eb});
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0;
    ren1 = 1'b0; ren2 = 1'b0; wen = 1'b0; mren = 1'b0;
    jen = 1'b0; jaddr = 32'd0; mstart = 1'b0; mdone = 1'b0;
  endtask

  task automatic set_lu_rs2();
    mren = 1'b1; wen = 1'b1; rd = 5'd5; rs2 = 5'd5; ren2 = 1'b1;
  endtask

  initial begin
    clr();
    rst_n = 1'b0;
    // Reset gates every output even with active requests.
    jen = 1'b1; jaddr = 32'hDEAD_BEEF; mstart = 1'b1; set_lu_rs2();
    @(posedge clk); @(posedge clk); #1;
    #1;
    chk("rst_addr_a", jadr_a, 32'd0);
    cyc("rst", c_ZERO, c_ZERO);
    rst_n = 1'b1; clr();
    cyc("idle", c_ZERO, c_ZERO);

    // Load-use on rs2: stall, LU_STALL ignores lu, then re-evaluated in IDLE.
    set_lu_rs2();
    cyc("lu0", c_LU, c_LU);
    cyc("lu1", c_ZERO, c_ZERO);
    cyc("lu2", c_LU, c_LU);
    clr();
    cyc("lu3", c_ZERO, c_ZERO);
    cyc("lu4", c_ZERO, c_ZERO);
    mren = 1'b1; wen = 1'b1; rd = 5'd7; rs1 = 5'd7; ren1 = 1'b1; rs2 = 5'd7;
    cyc("lu_rs1", c_LU, c_LU);
    clr();
    cyc("lu_rs1_st", c_ZERO, c_ZERO);

    // No false stall: x0 target, operand not read, not a write, not a load.
    set_lu_rs2(); rd = 5'd0; rs2 = 5'd0;
    cyc("nf_x0", c_ZERO, c_ZERO);
    set_lu_rs2(); ren2 = 1'b0;
    cyc("nf_ren", c_ZERO, c_ZERO);
    cyc("nf_ren2", c_ZERO, c_ZERO);
    set_lu_rs2(); wen = 1'b0;
    cyc("nf_wen", c_ZERO, c_ZERO);
    set_lu_rs2(); mren = 1'b0;
    cyc("nf_mren", c_ZERO, c_ZERO);
    set_lu_rs2(); rs2 = 5'd6;
    cyc("nf_addr", c_ZERO, c_ZERO);
    clr();

    // Jump beats load-use; A flushes 2 cycles, B goes back to IDLE at once.
    set_lu_rs2(); jen = 1'b1; jaddr = 32'h0000_0100;
    #1;
    chk("j0_addr_a", jadr_a, 32'h0000_0100);
    chk("j0_addr_b", jadr_b, 32'h0000_0100);
    cyc("j0", c_JF, c_JF);
    jen = 1'b0;
    cyc("j1", c_FL, c_LU);
    clr();
    cyc("j2", c_ZERO, c_ZERO);
    cyc("j3", c_ZERO, c_ZERO);

    // A second jump while A is in FLUSH is ignored there.
    jen = 1'b1; jaddr = 32'h0000_0200;
    cyc("jj0", c_JF, c_JF);
    jaddr = 32'h0000_0300;
    #1;
    chk("jj1_addr_b", jadr_b, 32'h0000_0300);
    cyc("jj1", c_FL, c_JF);
    clr();
    cyc("jj2", c_ZERO, c_ZERO);

    // Multi-cycle op done at cycle 10: A holds 0-9; B times out at cycle 8.
    for (int c = 0; c < 12; c++) begin
      mstart = (c == 0);
      mdone  = (c == 10);
      cyc($sformatf("mc%0d", c),
          (c <= 9) ? c_H3 : c_ZERO,
          (c <= 7) ? c_H3 : ((c == 8) ? c_TO : c_ZERO));
    end
    clr();

    // No done: A times out at cycle 16; jump and mc_start in MC_WAIT ignored.
    for (int c = 0; c < 18; c++) begin
      mstart = (c == 0) || (c == 1);
      jen    = (c == 3);
      jaddr  = 32'h0000_0400;
      cyc($sformatf("to%0d", c),
          (c <= 15) ? c_H3 : ((c == 16) ? c_TO : c_ZERO),
          (c <= 7) ? c_H3 : ((c == 8) ? c_TO : c_ZERO));
    end
    clr();

    // Reset mid-MC_WAIT: holds drop immediately, no timeout afterwards.
    mstart = 1'b1;
    cyc("rm0", c_H3, c_H3);
    mstart = 1'b0;
    cyc("rm1", c_H3, c_H3);
    cyc("rm2", c_H3, c_H3);
    rst_n = 1'b0;
    cyc("rm3", c_ZERO, c_ZERO);
    cyc("rm4", c_ZERO, c_ZERO);
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      cyc($sformatf("rm_post%0d", c), c_ZERO, c_ZERO);
    end

    // Reset mid-FLUSH abandons the remaining flush cycle.
    jen = 1'b1; jaddr = 32'h0000_0500;
    cyc("rf0", c_JF, c_JF);
    jen = 1'b0; rst_n = 1'b0;
    cyc("rf1", c_ZERO, c_ZERO);
    rst_n = 1'b1;
    cyc("rf2", c_ZERO, c_ZERO);

    // mc_done outside MC_WAIT has no effect.
    mdone = 1'b1;
    cyc("dn0", c_ZERO, c_ZERO);
    mdone = 1'b0;
    cyc("dn1", c_ZERO, c_ZERO);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
